// File: rtl/up_job_sched_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// up_job_sched_if : requester-side and copy-engine-side signals of up_job_sched
// Rev 1.0
// -----------------------------------------------------------------------------
interface up_job_sched_if #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH     = 15,
  parameter int FIFO_DEPTH     = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]                req_valid_i;
  logic [NUM_REQ-1:0]                req_ready_o;
  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_src_addr_i;
  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_dst_addr_i;
  logic [NUM_REQ*SIZE_WIDTH-1:0]     req_size_i;
  logic [NUM_REQ-1:0]                done_o;
  logic [AXI_ADDR_WIDTH-1:0]         src_addr_o;
  logic [AXI_ADDR_WIDTH-1:0]         dst_addr_o;
  logic [SIZE_WIDTH-1:0]             size_o;
  logic                              trigger_pulse_o;
  logic                              busy_i;
  logic [CNT_W-1:0]                  pending_o;
  logic                              idle_o;

  modport slave (
    input  req_valid_i, req_src_addr_i, req_dst_addr_i, req_size_i, busy_i,
    output req_ready_o, done_o, src_addr_o, dst_addr_o, size_o,
           trigger_pulse_o, pending_o, idle_o
  );

  modport master (
    output req_valid_i, req_src_addr_i, req_dst_addr_i, req_size_i, busy_i,
    input  req_ready_o, done_o, src_addr_o, dst_addr_o, size_o,
           trigger_pulse_o, pending_o, idle_o
  );
endinterface
`default_nettype wire

// File: rtl/up_job_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// up_job_sched : round-robin job queue launching copies one at a time on the engine
// Rev 1.0
// -----------------------------------------------------------------------------
module up_job_sched #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH     = 15,
  parameter int FIFO_DEPTH     = 4
) (
  input  wire logic     ACLK,
  input  wire logic     ARESET,
  up_job_sched_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [SIZE_WIDTH-1:0]     size_q, size_d;
  logic                      trigger_q, trigger_d;
  logic [NUM_REQ-1:0]        done_q, done_d;

  logic [ID_W-1:0]           id_mem   [FIFO_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] src_mem  [FIFO_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] dst_mem  [FIFO_DEPTH];
  logic [SIZE_WIDTH-1:0]     size_mem [FIFO_DEPTH];

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               full, empty, push, pop;
  int                 cand;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Scan from the highest offset down so the nearest valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    if (!full && !ARESET) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (bus.req_valid_i[ID_W'(cand)]) grant_idx = ID_W'(cand);
      end
      grant[grant_idx] = bus.req_valid_i[grant_idx];
    end
  end

  assign push = |grant;
  assign pop  = (state_q == S_IDLE) && !empty && !bus.busy_i;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= grant_idx;
      src_mem[wr_ptr_q]  <= bus.req_src_addr_i[AXI_ADDR_WIDTH*int'(grant_idx) +: AXI_ADDR_WIDTH];
      dst_mem[wr_ptr_q]  <= bus.req_dst_addr_i[AXI_ADDR_WIDTH*int'(grant_idx) +: AXI_ADDR_WIDTH];
      size_mem[wr_ptr_q] <= bus.req_size_i[SIZE_WIDTH*int'(grant_idx) +: SIZE_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    src_d     = src_q;
    dst_d     = dst_q;
    size_d    = size_q;
    trigger_d = 1'b0;
    done_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          id_d   = id_mem[rd_ptr_q];
          src_d  = src_mem[rd_ptr_q];
          dst_d  = dst_mem[rd_ptr_q];
          size_d = size_mem[rd_ptr_q];
          // Zero-byte jobs complete without ever starting the engine.
          if (size_mem[rd_ptr_q] != '0) begin
            state_d   = S_LAUNCH;
            trigger_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = ONE_HOT0 << id_mem[rd_ptr_q];
          end
        end
      end
      S_LAUNCH:     state_d = S_WAIT_START;
      S_WAIT_START: if (bus.busy_i) state_d = S_WAIT_END;
      S_WAIT_END: begin
        if (!bus.busy_i) begin
          state_d = S_DONE;
          done_d  = ONE_HOT0 << id_q;
        end
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      id_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      size_q    <= '0;
      trigger_q <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      id_q      <= id_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      trigger_q <= trigger_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready_o     = grant;
  assign bus.done_o          = done_q;
  assign bus.src_addr_o      = src_q;
  assign bus.dst_addr_o      = dst_q;
  assign bus.size_o          = size_q;
  assign bus.trigger_pulse_o = trigger_q;
  assign bus.pending_o       = count_q;
  assign bus.idle_o          = empty && (state_q == S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_up_job_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_up_job_sched : directed self-checking bench for up_job_sched
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_up_job_sched;
  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int SW      = 15;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   bcnt     = 0;
  int   acc      = 0;
  int   ng       = 0;
  logic seen;
  logic [3:0]    grants [8];
  logic [3:0]    one_hot;
  logic [AW-1:0] launched [$];

  up_job_sched_if #(.NUM_REQ(NUM_REQ), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                    .FIFO_DEPTH(DEPTH)) bus ();

  up_job_sched #(.NUM_REQ(NUM_REQ), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                 .FIFO_DEPTH(DEPTH)) u_dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [SW-1:0] sz);
    bus.req_src_addr_i[r*AW +: AW] = src;
    bus.req_dst_addr_i[r*AW +: AW] = dst;
    bus.req_size_i[r*SW +: SW]     = sz;
  endtask

  // Engine model: busy rises after a trigger and stays high for two cycles.
  task automatic engine_step();
    if (bus.trigger_pulse_o) begin
      launched.push_back(bus.src_addr_o);
      bcnt       = 2;
      bus.busy_i = 1'b1;
    end else if (bcnt > 0) begin
      bcnt--;
      bus.busy_i = (bcnt != 0);
    end
  endtask

  task automatic drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      engine_step();
      if (bus.idle_o && bcnt == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_drain"}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.busy_i      = 1'b0;
    bcnt            = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    bus.req_valid_i    = '0;
    bus.req_src_addr_i = '0;
    bus.req_dst_addr_i = '0;
    bus.req_size_i     = '0;
    bus.busy_i         = 1'b0;
    do_reset();

    chk("rst_ready",   64'(bus.req_ready_o),     64'd0);
    chk("rst_done",    64'(bus.done_o),          64'd0);
    chk("rst_trig",    64'(bus.trigger_pulse_o), 64'd0);
    chk("rst_src",     64'(bus.src_addr_o),      64'd0);
    chk("rst_size",    64'(bus.size_o),          64'd0);
    chk("rst_pending", 64'(bus.pending_o),       64'd0);
    chk("rst_idle",    64'(bus.idle_o),          64'd1);

    // Single job from requester 2
    set_req(2, 32'h1000, 32'h2000, 15'd64);
    bus.req_valid_i = 4'b0100;
    #1 chk("t1_ready", 64'(bus.req_ready_o), 64'h4);
    @(negedge clk);
    bus.req_valid_i = '0;
    chk("t1_pending", 64'(bus.pending_o), 64'd1);
    chk("t1_trig_c1", 64'(bus.trigger_pulse_o), 64'd0);
    @(negedge clk);
    chk("t1_trig", 64'(bus.trigger_pulse_o), 64'd1);
    chk("t1_src",  64'(bus.src_addr_o), 64'h1000);
    chk("t1_dst",  64'(bus.dst_addr_o), 64'h2000);
    chk("t1_size", 64'(bus.size_o),     64'd64);
    bus.busy_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | (bus.done_o != 0) | bus.trigger_pulse_o;
    end
    chk("t1_quiet", 64'(seen), 64'd0);
    bus.busy_i = 1'b0;
    @(negedge clk);
    chk("t1_done", 64'(bus.done_o), 64'h4);
    @(negedge clk);
    chk("t1_done_clr", 64'(bus.done_o), 64'd0);
    chk("t1_idle",     64'(bus.idle_o), 64'd1);

    // Zero-size job from requester 1
    set_req(1, 32'h55, 32'h66, 15'd0);
    bus.req_valid_i = 4'b0010;
    #1 chk("t4_ready", 64'(bus.req_ready_o), 64'h2);
    @(negedge clk);
    bus.req_valid_i = '0;
    seen = bus.trigger_pulse_o;
    chk("t4_done_c1", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    seen = seen | bus.trigger_pulse_o;
    chk("t4_done", 64'(bus.done_o), 64'h2);
    @(negedge clk);
    seen = seen | bus.trigger_pulse_o;
    chk("t4_no_trig",  64'(seen),       64'd0);
    chk("t4_done_clr", 64'(bus.done_o), 64'd0);
    chk("t4_idle",     64'(bus.idle_o), 64'd1);

    // Full FIFO behind a running job
    set_req(0, 32'h3000, 32'h3100, 15'd16);
    bus.req_valid_i = 4'b0001;
    #1 chk("t3_ready0", 64'(bus.req_ready_o), 64'h1);
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("t3_trig", 64'(bus.trigger_pulse_o), 64'd1);
    bus.busy_i = 1'b1;
    set_req(3, 32'h3300, 32'h3400, 15'd32);
    bus.req_valid_i = 4'b1000;
    acc = 0;
    repeat (4) begin
      #1 if (bus.req_ready_o == 4'b1000) acc++;
      @(negedge clk);
    end
    chk("t3_accepts", 64'(acc), 64'd4);
    #1 chk("t3_pending_full", 64'(bus.pending_o),   64'd4);
    chk("t3_ready_full",      64'(bus.req_ready_o), 64'd0);
    bus.busy_i = 1'b0;
    @(negedge clk);
    chk("t3_done",         64'(bus.done_o),      64'h1);
    chk("t3_ready_done",   64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    chk("t3_ready_popcyc", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    chk("t3_ready_back",   64'(bus.req_ready_o), 64'h8);
    chk("t3_pending_3",    64'(bus.pending_o),   64'd3);
    bus.req_valid_i = '0;
    drain("t3");

    // Reset while a job is in WAIT_END with three more queued
    set_req(0, 32'h5000, 32'h5100, 15'd8);
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("t5_trig", 64'(bus.trigger_pulse_o), 64'd1);
    bus.busy_i = 1'b1;
    set_req(2, 32'h5200, 32'h5300, 15'd8);
    bus.req_valid_i = 4'b0100;
    repeat (3) @(negedge clk);
    bus.req_valid_i = '0;
    chk("t5_pending_pre", 64'(bus.pending_o), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_pending_rst", 64'(bus.pending_o), 64'd0);
    chk("t5_idle_rst",    64'(bus.idle_o),    64'd1);
    chk("t5_done_rst",    64'(bus.done_o),    64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (bus.done_o != 0) | bus.trigger_pulse_o;
    end
    set_req(3, 32'h5400, 32'h5500, 15'd8);
    bus.req_valid_i = 4'b1000;
    #1 chk("t5_ready_new", 64'(bus.req_ready_o), 64'h8);
    @(negedge clk);
    bus.req_valid_i = '0;
    repeat (4) begin
      seen = seen | (bus.done_o != 0) | bus.trigger_pulse_o;
      @(negedge clk);
    end
    chk("t5_held",       64'(seen),          64'd0);
    chk("t5_pending_1",  64'(bus.pending_o), 64'd1);
    bus.busy_i = 1'b0;
    @(negedge clk);
    chk("t5_trig_after", 64'(bus.trigger_pulse_o), 64'd1);
    chk("t5_src_after",  64'(bus.src_addr_o),      64'h5400);
    drain("t5");

    // Round-robin with all requesters valid while the queue drains
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'((i + 1) * 32'h100), 32'h0, 15'd8);
    bus.req_valid_i = 4'b1111;
    ng = 0;
    for (int cyc = 0; cyc < 200 && ng < 8; cyc++) begin
      engine_step();
      #1;
      if (bus.req_ready_o != 0) begin
        grants[ng] = bus.req_ready_o;
        ng++;
      end
      @(negedge clk);
    end
    bus.req_valid_i = '0;
    chk("rr_count", 64'(ng), 64'd8);
    for (int k = 0; k < 8; k++) begin
      one_hot = 4'b0001;
      one_hot = one_hot << (k % 4);
      chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(one_hot));
    end
    drain("rr");

    // Push and pop in the same cycle, launches stay in FIFO order
    launched.delete();
    set_req(0, 32'hA0, 32'hA1, 15'd4);
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("t6_trig", 64'(bus.trigger_pulse_o), 64'd1);
    bus.busy_i = 1'b1;
    set_req(1, 32'hB0, 32'hB1, 15'd4);
    bus.req_valid_i = 4'b0010;
    @(negedge clk);
    set_req(2, 32'hC0, 32'hC1, 15'd4);
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    bus.req_valid_i = '0;
    chk("t6_pending_2", 64'(bus.pending_o), 64'd2);
    bus.busy_i = 1'b0;
    @(negedge clk);
    chk("t6_done_a", 64'(bus.done_o), 64'h1);
    @(negedge clk);
    set_req(3, 32'hD0, 32'hD1, 15'd4);
    bus.req_valid_i = 4'b1000;
    #1 chk("t6_ready", 64'(bus.req_ready_o), 64'h8);
    @(negedge clk);
    bus.req_valid_i = '0;
    chk("t6_pending_same", 64'(bus.pending_o), 64'd2);
    drain("t6");
    chk("t6_launch_n", 64'(launched.size()), 64'd3);
    chk("t6_order0",   64'(launched[0]),     64'hB0);
    chk("t6_order1",   64'(launched[1]),     64'hC0);
    chk("t6_order2",   64'(launched[2]),     64'hD0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
